spi_frame_capture: RTL and testbench

SPI_FRAME_CAPTURE -- requirements
Module: spi_frame_capture

---
 rtl/spi_frame_capture.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_frame_capture.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_capture.sv
// spi_frame_capture
//   Snoops a 4-wire SPI display bus: command bytes (dc=0) and data bytes (dc=1).
//   Tracks the CASET/PASET address window and RAMWR pixel stream. Emits one
//   strobe per assembled pixel, carrying its linear frame address.
//
// Ports
//   clk, rst           system clock; synchronous active-high reset
//   spi_sck/cs/dc/mosi raw SPI inputs, asynchronous to clk
//   pix_valid          one-cycle strobe qualifying pix_addr / pix_data
//   pix_addr           row*WIDTH + col of the emitted pixel
//   pix_data           {high byte, low byte}
//   frame_done         strobes with the pixel at (col_end,row_end)
//   ram_wr_active      high while the command state is RAMWR
//   cmd_valid/cmd_byte present only with SPI_FRAME_CAPTURE_CMD_OUT_EN; one
//                      strobe per command byte, same latency as pix_valid
//
// Optional feature macro: SPI_FRAME_CAPTURE_CMD_OUT_EN
//
// Handshake: pix_valid (and cmd_valid) are pure strobes with no ready; the
// consumer must accept the qualified data in the cycle the strobe is high.
module spi_frame_capture #(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 128,
  parameter int PIXEL_SIZE = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              spi_sck,
  input  logic                              spi_cs,
  input  logic                              spi_dc,
  input  logic                              spi_mosi,
  output logic                              pix_valid,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   pix_addr,
  output logic [PIXEL_SIZE-1:0]             pix_data,
  output logic                              frame_done,
`ifdef SPI_FRAME_CAPTURE_CMD_OUT_EN
  output logic                              cmd_valid,
  output logic [7:0]                        cmd_byte,
`endif
  output logic                              ram_wr_active
);

  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR, S_SKIP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d;   // {sck, cs, dc, mosi}
  logic            sck_prev_q, sck_prev_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      param_cnt_q, param_cnt_d;
  logic [23:0]     param_q, param_d;
  logic [CW-1:0]   col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
  logic [RW-1:0]   row_start_q, row_start_d, row_end_q, row_end_d, row_q, row_d;
  logic            hi_pend_q, hi_pend_d;
  logic [7:0]      hi_byte_q, hi_byte_d;
  logic            pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
  logic [AW-1:0]   pix_addr_q, pix_addr_d;
  logic [PIXEL_SIZE-1:0] pix_data_q, pix_data_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      cmd_byte_q, cmd_byte_d;

  logic            sck_s, cs_s, dc_s, mosi_s, sck_rise, byte_done;
  logic [7:0]      byte_val;
  logic [15:0]     p_start, p_end, c_start, c_end, lim;
  logic [AW-1:0]   addr_now;

  assign sck_s     = sync2_q[3];
  assign cs_s      = sync2_q[2];
  assign dc_s      = sync2_q[1];
  assign mosi_s    = sync2_q[0];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign byte_done = sck_rise & ~cs_s & (bit_cnt_q == 3'd7);
  assign byte_val  = {shift_q[6:0], mosi_s};
  assign addr_now  = AW'(row_q) * AW'(WIDTH) + AW'(col_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: only command bytes move the FSM
  always_comb begin
    state_d = state_q;
    if (byte_done && !dc_s) begin
      case (byte_val)
        8'h2A:   state_d = S_CASET;
        8'h2B:   state_d = S_PASET;
        8'h2C:   state_d = S_RAMWR;
        default: state_d = S_SKIP;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    ram_wr_active = (state_q == S_RAMWR);
  end

  // Datapath next-state
  always_comb begin
    sync1_d      = {spi_sck, spi_cs, spi_dc, spi_mosi};
    sync2_d      = sync1_q;
    sck_prev_d   = sck_s;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    param_cnt_d  = param_cnt_q;
    param_d      = param_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    row_start_d  = row_start_q;
    row_end_d    = row_end_q;
    col_d        = col_q;
    row_d        = row_q;
    hi_pend_d    = hi_pend_q;
    hi_byte_d    = hi_byte_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    pix_addr_d   = pix_addr_q;
    pix_data_d   = pix_data_q;
    cmd_valid_d  = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    p_start      = param_q[23:8];
    p_end        = {param_q[7:0], byte_val};
    lim          = (state_q == S_CASET) ? 16'(WIDTH - 1) : 16'(HEIGHT - 1);
    c_start      = (p_start > lim) ? lim : p_start;
    c_end        = (p_end   > lim) ? lim : p_end;

    // Deselect drops any partial byte; command/pixel context survives.
    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = byte_val;
    end

    if (byte_done && !dc_s) begin
      param_cnt_d = 3'd0;
      hi_pend_d   = 1'b0;          // orphaned high byte is dropped
      cmd_valid_d = 1'b1;
      cmd_byte_d  = byte_val;
      if (byte_val == 8'h2C) begin
        col_d = col_start_q;
        row_d = row_start_q;
      end
    end else if (byte_done) begin
      case (state_q)
        S_CASET, S_PASET: begin
          if (param_cnt_q < 3'd4) begin
            param_cnt_d = param_cnt_q + 3'd1;
            case (param_cnt_q)
              3'd0:    param_d[23:16] = byte_val;
              3'd1:    param_d[15:8]  = byte_val;
              3'd2:    param_d[7:0]   = byte_val;
              default: begin
                // Fourth byte: commit the clamped window only if well ordered.
                if (c_start <= c_end) begin
                  if (state_q == S_CASET) begin
                    col_start_d = CW'(c_start);
                    col_end_d   = CW'(c_end);
                  end else begin
                    row_start_d = RW'(c_start);
                    row_end_d   = RW'(c_end);
                  end
                end
              end
            endcase
          end
        end
        S_RAMWR: begin
          if (!hi_pend_q) begin
            hi_pend_d = 1'b1;
            hi_byte_d = byte_val;
          end else begin
            hi_pend_d   = 1'b0;
            pix_valid_d = 1'b1;
            pix_addr_d  = addr_now;
            pix_data_d  = PIXEL_SIZE'({hi_byte_q, byte_val});
            if (col_q == col_end_q) begin
              col_d = col_start_q;
              if (row_q == row_end_q) begin
                row_d        = row_start_q;
                frame_done_d = 1'b1;
              end else begin
                row_d = row_q + RW'(1);
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sck_prev_q   <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      param_cnt_q  <= '0;
      param_q      <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(WIDTH - 1);
      row_start_q  <= '0;
      row_end_q    <= RW'(HEIGHT - 1);
      col_q        <= '0;
      row_q        <= '0;
      hi_pend_q    <= 1'b0;
      hi_byte_q    <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sck_prev_q   <= sck_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      param_cnt_q  <= param_cnt_d;
      param_q      <= param_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      row_start_q  <= row_start_d;
      row_end_q    <= row_end_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hi_pend_q    <= hi_pend_d;
      hi_byte_q    <= hi_byte_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_byte_q   <= cmd_byte_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign frame_done = frame_done_q;

`ifdef SPI_FRAME_CAPTURE_CMD_OUT_EN
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
`else
  logic unused_cmd;
  assign unused_cmd = cmd_valid_q ^ (^cmd_byte_q);
`endif

endmodule

// File: tb/tb_spi_frame_capture.sv
// tb_spi_frame_capture
//   Drives SPI byte sequences into spi_frame_capture and checks pixel strobes
//   against a queue of expected {addr, data, frame_done} records.
module tb_spi_frame_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sck = 1'b0, spi_cs = 1'b1, spi_dc = 1'b0, spi_mosi = 1'b0;
  logic        pix_valid, frame_done, ram_wr_active;
  logic [13:0] pix_addr;
  logic [15:0] pix_data;
`ifdef SPI_FRAME_CAPTURE_CMD_OUT_EN
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic [7:0]  cmd_exp_q[$];
`endif

  int checks = 0;
  int failures = 0;

  logic [30:0] exp_q[$];   // {addr[13:0], data[15:0], frame_done}

  typedef struct {
    bit          rst_first;
    bit          dc;
    logic [7:0]  val;
    bit          exp_pix;
    int          exp_addr;
    logic [15:0] exp_data;
    bit          exp_fd;
    bit          exp_ram;
  } vec_t;
  vec_t tbl[$];

  spi_frame_capture dut (
    .clk           (clk),
    .rst           (rst),
    .spi_sck       (spi_sck),
    .spi_cs        (spi_cs),
    .spi_dc        (spi_dc),
    .spi_mosi      (spi_mosi),
    .pix_valid     (pix_valid),
    .pix_addr      (pix_addr),
    .pix_data      (pix_data),
    .frame_done    (frame_done),
`ifdef SPI_FRAME_CAPTURE_CMD_OUT_EN
    .cmd_valid     (cmd_valid),
    .cmd_byte      (cmd_byte),
`endif
    .ram_wr_active (ram_wr_active)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic send_bits(input bit dc, input logic [7:0] val, input int n);
    @(negedge clk);
    spi_cs = 1'b0;
    spi_dc = dc;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = val[i];
      repeat (3) @(negedge clk);
      spi_sck = 1'b1;
      repeat (3) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] val);
`ifdef SPI_FRAME_CAPTURE_CMD_OUT_EN
    if (!dc) cmd_exp_q.push_back(val);
`endif
    send_bits(dc, val, 8);
  endtask

  task automatic send_pixel(input logic [15:0] d, input int addr, input bit fd);
    send_byte(1'b1, d[15:8]);
    exp_q.push_back({14'(addr), d, fd});
    send_byte(1'b1, d[7:0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    spi_cs  = 1'b1;
    spi_sck = 1'b0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check(name, exp_q.size(), 0);
`ifdef SPI_FRAME_CAPTURE_CMD_OUT_EN
    check({name, "_cmd"}, cmd_exp_q.size(), 0);
`endif
  endtask

  task automatic add(input bit r, input bit dc, input logic [7:0] v, input bit p,
                     input int a, input logic [15:0] d, input bit fd, input bit ram);
    tbl.push_back('{r, dc, v, p, a, d, fd, ram});
  endtask

  // Scoreboard: pop one expectation per pixel strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel addr=%0d data=0x%h expected=none", pix_addr, pix_data);
        end else begin
          logic [30:0] e;
          e = exp_q.pop_front();
          check("pix_addr", 32'(pix_addr), 32'(e[30:17]));
          check("pix_data", 32'(pix_data), 32'(e[16:1]));
          check("frame_done", 32'(frame_done), 32'(e[0]));
        end
      end else if (frame_done) begin
        checks++;
        failures++;
        $display("FAIL frame_done_without_pixel actual=1 expected=0");
      end
`ifdef SPI_FRAME_CAPTURE_CMD_OUT_EN
      if (cmd_valid) begin
        if (cmd_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd byte=0x%h expected=none", cmd_byte);
        end else begin
          check("cmd_byte", 32'(cmd_byte), 32'(cmd_exp_q.pop_front()));
        end
      end
`endif
    end
  end

  initial begin
    // Table: {rst_first, dc, byte, exp_pix, addr, data, fd, ram_wr_active after}
    // Single pixel after reset
    add(1, 0, 8'h2C, 0, 0,   16'h0000, 0, 1);
    add(0, 1, 8'hF8, 0, 0,   16'h0000, 0, 1);
    add(0, 1, 8'h00, 1, 0,   16'hF800, 0, 1);
    // 2x1 window at cols 10..11, row 5
    add(0, 0, 8'h2A, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h0A, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h0B, 0, 0, 0, 0, 0);
    add(0, 0, 8'h2B, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h05, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h05, 0, 0, 0, 0, 0);
    add(0, 0, 8'h2C, 0, 0, 0, 0, 1);
    add(0, 1, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, 8'h01, 1, 650, 16'h0001, 0, 1);
    add(0, 1, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, 8'h02, 1, 651, 16'h0002, 1, 1);
    add(0, 1, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, 8'h03, 1, 650, 16'h0003, 0, 1);
    add(0, 1, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, 8'h04, 1, 651, 16'h0004, 1, 1);
    // Pending high byte dropped by a command
    add(0, 1, 8'h12, 0, 0, 0, 0, 1);
    add(0, 0, 8'h2C, 0, 0, 0, 0, 1);
    add(0, 1, 8'h34, 0, 0, 0, 0, 1);
    add(0, 1, 8'h56, 1, 650, 16'h3456, 0, 1);
    // Clamp: CASET 0,200,0,255 -> column 127 only
    add(1, 0, 8'h2A, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'hC8, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 0, 0, 0, 0);
    add(0, 0, 8'h2C, 0, 0, 0, 0, 1);
    add(0, 1, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, 8'h01, 1, 127, 16'h0001, 0, 1);
    add(0, 1, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, 8'h02, 1, 255, 16'h0002, 0, 1);
    // Reversed window ignored
    add(0, 0, 8'h2A, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h14, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, 8'h0A, 0, 0, 0, 0, 0);
    // Unknown command: data ignored
    add(0, 0, 8'h55, 0, 0, 0, 0, 0);
    add(0, 1, 8'h11, 0, 0, 0, 0, 0);
    add(0, 1, 8'h22, 0, 0, 0, 0, 0);
    add(0, 0, 8'h2C, 0, 0, 0, 0, 1);
    add(0, 1, 8'h00, 0, 0, 0, 0, 1);
    add(0, 1, 8'h03, 1, 127, 16'h0003, 0, 1);

    // Reset state
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_addr", 32'(pix_addr), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_ram_wr_active", 32'(ram_wr_active), 0);
`ifdef SPI_FRAME_CAPTURE_CMD_OUT_EN
    check("rst_cmd_valid", 32'(cmd_valid), 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (tbl[k]) begin
      if (tbl[k].rst_first) begin
        wait_drain("table_drain");
        do_reset();
      end
      if (tbl[k].exp_pix)
        exp_q.push_back({14'(tbl[k].exp_addr), tbl[k].exp_data, tbl[k].exp_fd});
      send_byte(tbl[k].dc, tbl[k].val);
      repeat (2) @(negedge clk);
      check($sformatf("ram_wr_active_%0d", k), 32'(ram_wr_active), 32'(tbl[k].exp_ram));
    end
    wait_drain("table_drain");

    // Mid-byte reset: outputs return to reset values, no pixel, capture resumes
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h12);
    send_byte(1'b0, 8'h00);
    send_bits(1'b1, 8'hA5, 4);
    spi_cs = 1'b1;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_pix_valid", 32'(pix_valid), 0);
    check("midrst_pix_addr", 32'(pix_addr), 0);
    check("midrst_pix_data", 32'(pix_data), 0);
    check("midrst_frame_done", 32'(frame_done), 0);
    check("midrst_ram_wr_active", 32'(ram_wr_active), 0);
    repeat (3) @(negedge clk);
    send_byte(1'b0, 8'h2C);
    send_pixel(16'hF800, 0, 0);
    wait_drain("midrst_drain");

    // Partial byte then deselect: only the following full bytes count
    do_reset();
    send_byte(1'b0, 8'h2C);
    send_bits(1'b1, 8'hFF, 5);
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    send_pixel(16'hABCD, 0, 0);
    wait_drain("partial_drain");
    check("partial_ram_wr_active", 32'(ram_wr_active), 1);

    // Last row of the frame: full-width wrap and frame end at 16383
    do_reset();
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h7F);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h7F);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 128; i++)
      send_pixel(16'(i * 257 + $urandom_range(0, 3)), 16256 + i, i == 127);
    send_pixel(16'h1234, 16256, 0);
    wait_drain("lastrow_drain");
    // Restore full window: next frame starts at address 0
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h7F);
    send_byte(1'b0, 8'h2C);
    send_pixel(16'h5A5A, 0, 0);
    wait_drain("wrap_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
